// File: rtl/uart_rx_frame_engine_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_frame_engine_if - serial line, frame configuration and frame results
// Rev 1.0
// ----------------------------------------------------------------------------
interface uart_rx_frame_engine_if #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESC_W    = 6
);
   logic                  RX_IN;
   logic [PRESC_W-1:0]    Prescale;
   logic                  Parity_EN;
   logic                  Parity_type;
   logic                  Two_stop;
   logic [DATA_WIDTH-1:0] Parallel_data;
   logic                  Data_valid;
   logic                  Parity_err;
   logic                  Stop_err;
   logic                  Busy;

   modport slave (
      input  RX_IN, Prescale, Parity_EN, Parity_type, Two_stop,
      output Parallel_data, Data_valid, Parity_err, Stop_err, Busy
   );

   modport master (
      output RX_IN, Prescale, Parity_EN, Parity_type, Two_stop,
      input  Parallel_data, Data_valid, Parity_err, Stop_err, Busy
   );
endinterface
`default_nettype wire

// File: rtl/uart_rx_frame_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_frame_engine - oversampled UART receiver with 3-sample majority vote
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_rx_frame_engine #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESC_W    = 6
) (
   input  wire                   Clk,
   input  wire                   Rst,
   uart_rx_frame_engine_if.slave bus
);
   localparam int BIT_W = $clog2(DATA_WIDTH + 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic                  sync1_q, sync1_d;
   logic                  rx_s_q, rx_s_d;
   logic [PRESC_W-1:0]    edge_cnt_q, edge_cnt_d;
   logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [PRESC_W-1:0]    presc_q, presc_d;
   logic                  par_en_q, par_en_d;
   logic                  par_type_q, par_type_d;
   logic                  two_stop_q, two_stop_d;
   logic                  samp0_q, samp0_d;
   logic                  samp1_q, samp1_d;
   logic                  samp2_q, samp2_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  par_bit_q, par_bit_d;
   logic                  stop_sticky_q, stop_sticky_d;
   logic                  data_valid_q, data_valid_d;
   logic                  parity_err_q, parity_err_d;
   logic                  stop_err_q, stop_err_d;
   logic                  busy_q, busy_d;

   logic [PRESC_W-1:0]    half, half_m1, half_p1, last_edge;
   logic                  at_s0, at_s1, at_s2, at_last;
   logic                  third, maj;
   logic                  last_data, last_stop;
   logic                  parity_bad, stop_bad;

   assign half      = presc_q >> 1;
   assign half_m1   = half - PRESC_W'(1);
   assign half_p1   = half + PRESC_W'(1);
   assign last_edge = presc_q - PRESC_W'(1);

   assign at_s0   = (edge_cnt_q == half_m1);
   assign at_s1   = (edge_cnt_q == half);
   assign at_s2   = (edge_cnt_q == half_p1);
   assign at_last = (edge_cnt_q == last_edge);

   // On the third sample edge the vote uses the live line so the bit is usable that cycle
   assign third = at_s2 ? rx_s_q : samp2_q;
   assign maj   = (samp0_q & samp1_q) | (samp0_q & third) | (samp1_q & third);

   assign last_data  = (bit_cnt_q == BIT_W'(DATA_WIDTH - 1));
   assign last_stop  = (bit_cnt_q == {{(BIT_W-1){1'b0}}, two_stop_q});
   assign parity_bad = par_en_q & (((^shift_q) ^ par_bit_q) != par_type_q);
   assign stop_bad   = stop_sticky_q | ~maj;

   always_comb begin
      sync1_d       = bus.RX_IN;
      rx_s_d        = sync1_q;
      state_d       = state_q;
      edge_cnt_d    = edge_cnt_q;
      bit_cnt_d     = bit_cnt_q;
      presc_d       = presc_q;
      par_en_d      = par_en_q;
      par_type_d    = par_type_q;
      two_stop_d    = two_stop_q;
      samp0_d       = samp0_q;
      samp1_d       = samp1_q;
      samp2_d       = samp2_q;
      shift_d       = shift_q;
      data_out_d    = data_out_q;
      par_bit_d     = par_bit_q;
      stop_sticky_d = stop_sticky_q;
      data_valid_d  = 1'b0;
      parity_err_d  = 1'b0;
      stop_err_d    = 1'b0;

      if (state_q != ST_IDLE) begin
         if (at_s0) samp0_d = rx_s_q;
         if (at_s1) samp1_d = rx_s_q;
         if (at_s2) samp2_d = rx_s_q;
         edge_cnt_d = at_last ? '0 : edge_cnt_q + PRESC_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            // The detection cycle itself is edge 0 of the start bit
            if (!rx_s_q) begin
               state_d       = ST_START;
               edge_cnt_d    = PRESC_W'(1);
               bit_cnt_d     = '0;
               presc_d       = bus.Prescale;
               par_en_d      = bus.Parity_EN;
               par_type_d    = bus.Parity_type;
               two_stop_d    = bus.Two_stop;
               stop_sticky_d = 1'b0;
            end
         end
         ST_START: begin
            if (at_last) begin
               state_d   = maj ? ST_IDLE : ST_DATA;
               bit_cnt_d = '0;
            end
         end
         ST_DATA: begin
            if (at_s2) shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
            if (at_last) begin
               if (last_data) begin
                  bit_cnt_d = '0;
                  state_d   = par_en_q ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end
         ST_PARITY: begin
            if (at_s2) par_bit_d = maj;
            if (at_last) begin
               state_d   = ST_STOP;
               bit_cnt_d = '0;
            end
         end
         ST_STOP: begin
            // Frame closes mid final stop bit, leaving margin for the next start edge
            if (at_s2 && last_stop) begin
               state_d      = ST_IDLE;
               edge_cnt_d   = '0;
               bit_cnt_d    = '0;
               stop_err_d   = stop_bad;
               parity_err_d = parity_bad;
               if (!stop_bad && !parity_bad) begin
                  data_valid_d = 1'b1;
                  data_out_d   = shift_q;
               end
            end else begin
               if (at_s2) stop_sticky_d = stop_bad;
               if (at_last) bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
         end
         default: begin
            state_d    = ST_IDLE;
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q       <= ST_IDLE;
         sync1_q       <= 1'b1;
         rx_s_q        <= 1'b1;
         edge_cnt_q    <= '0;
         bit_cnt_q     <= '0;
         presc_q       <= '0;
         par_en_q      <= 1'b0;
         par_type_q    <= 1'b0;
         two_stop_q    <= 1'b0;
         samp0_q       <= 1'b0;
         samp1_q       <= 1'b0;
         samp2_q       <= 1'b0;
         shift_q       <= '0;
         data_out_q    <= '0;
         par_bit_q     <= 1'b0;
         stop_sticky_q <= 1'b0;
         data_valid_q  <= 1'b0;
         parity_err_q  <= 1'b0;
         stop_err_q    <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         sync1_q       <= sync1_d;
         rx_s_q        <= rx_s_d;
         edge_cnt_q    <= edge_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         presc_q       <= presc_d;
         par_en_q      <= par_en_d;
         par_type_q    <= par_type_d;
         two_stop_q    <= two_stop_d;
         samp0_q       <= samp0_d;
         samp1_q       <= samp1_d;
         samp2_q       <= samp2_d;
         shift_q       <= shift_d;
         data_out_q    <= data_out_d;
         par_bit_q     <= par_bit_d;
         stop_sticky_q <= stop_sticky_d;
         data_valid_q  <= data_valid_d;
         parity_err_q  <= parity_err_d;
         stop_err_q    <= stop_err_d;
         busy_q        <= busy_d;
      end
   end

   assign bus.Parallel_data = data_out_q;
   assign bus.Data_valid    = data_valid_q;
   assign bus.Parity_err    = parity_err_q;
   assign bus.Stop_err      = stop_err_q;
   assign bus.Busy          = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_rx_frame_engine - pin-level frame generator with timing/result model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_uart_rx_frame_engine;
   logic       Clk = 1'b0;
   logic       Rst;
   logic [5:0] presc;
   logic       pen, ptype, two;
   bit         pin;
   bit         sel;

   always #5 Clk = ~Clk;

   uart_rx_frame_engine_if #(.DATA_WIDTH(8), .PRESC_W(6)) if8 ();
   uart_rx_frame_engine_if #(.DATA_WIDTH(7), .PRESC_W(6)) if7 ();

   uart_rx_frame_engine #(.DATA_WIDTH(8), .PRESC_W(6)) u_dut8 (.Clk(Clk), .Rst(Rst), .bus(if8));
   uart_rx_frame_engine #(.DATA_WIDTH(7), .PRESC_W(6)) u_dut7 (.Clk(Clk), .Rst(Rst), .bus(if7));

   assign if8.RX_IN       = sel ? 1'b1 : pin;
   assign if7.RX_IN       = sel ? pin : 1'b1;
   assign if8.Prescale    = presc;
   assign if7.Prescale    = presc;
   assign if8.Parity_EN   = pen;
   assign if7.Parity_EN   = pen;
   assign if8.Parity_type = ptype;
   assign if7.Parity_type = ptype;
   assign if8.Two_stop    = two;
   assign if7.Two_stop    = two;

   wire [8:0] o_data = sel ? {2'b00, if7.Parallel_data} : {1'b0, if8.Parallel_data};
   wire       o_dv   = sel ? if7.Data_valid : if8.Data_valid;
   wire       o_pe   = sel ? if7.Parity_err : if8.Parity_err;
   wire       o_se   = sel ? if7.Stop_err   : if8.Stop_err;
   wire       o_busy = sel ? if7.Busy       : if8.Busy;

   typedef struct { int cyc; bit v; bit pe; bit se; logic [8:0] d; } ev_t;
   typedef struct { int cyc; bit b; } bz_t;

   bit         pinq[$];
   ev_t        evq[$];
   bz_t        bzq[$];
   logic [8:0] good_w [0:1];
   int         tests, fails;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic add_idle(input int n);
      for (int k = 0; k < n; k++) pinq.push_back(1'b1);
   endtask

   // Builds a frame waveform (one entry per clock) and the outcome the block must report.
   task automatic add_frame(input int dw, input int p, input logic [8:0] data,
                            input bit en, input bit typ, input bit tw, input bit pflip,
                            input bit [1:0] stop_vals, input bit noise, input int keep);
      bit         bits[$];
      bit         wav[$];
      int         s, n, half, strobe;
      logic [8:0] dm;
      bit         pe, se, v;
      dm = data & ((9'h1 << dw) - 9'h1);
      bits.push_back(1'b0);
      for (int i = 0; i < dw; i++) bits.push_back(dm[i]);
      if (en) bits.push_back((^dm) ^ typ ^ pflip);
      bits.push_back(stop_vals[0]);
      if (tw) bits.push_back(stop_vals[1]);
      s    = pinq.size();
      n    = bits.size() - 1;
      half = p / 2;
      foreach (bits[b])
         for (int k = 0; k < p; k++) wav.push_back((noise && k == half) ? ~bits[b] : bits[b]);
      bzq.push_back('{s + 2, 1'b0});
      bzq.push_back('{s + 3, 1'b1});
      if (keep > 0) begin
         for (int k = 0; k < keep; k++) pinq.push_back(wav[k]);
      end else begin
         foreach (wav[k]) pinq.push_back(wav[k]);
         pe = en && pflip;
         se = !stop_vals[0] || (tw && !stop_vals[1]);
         v  = !pe && !se;
         if (v) good_w[sel] = dm;
         strobe = s + 2 + n * p + half + 2;
         evq.push_back('{strobe, v, pe, se, good_w[sel]});
         bzq.push_back('{strobe - 1, 1'b1});
         bzq.push_back('{strobe, 1'b0});
      end
   endtask

   task automatic add_glitch(input int p);
      int s;
      s = pinq.size();
      for (int k = 0; k < 3; k++) pinq.push_back(1'b0);
      add_idle(p + 4);
      bzq.push_back('{s + 3, 1'b1});
      bzq.push_back('{s + 2 + p - 1, 1'b1});
      bzq.push_back('{s + 2 + p, 1'b0});
   endtask

   task automatic play(input int rst_at);
      int  last, spurious;
      bit  hit;
      last = pinq.size();
      foreach (evq[j]) if (evq[j].cyc + 2 > last) last = evq[j].cyc + 2;
      spurious = 0;
      for (int i = 0; i < last; i++) begin
         @(posedge Clk);
         #1;
         hit = 1'b0;
         foreach (evq[j]) begin
            if (evq[j].cyc == i) begin
               hit = 1'b1;
               chk("data_valid", o_dv, evq[j].v);
               chk("parity_err", o_pe, evq[j].pe);
               chk("stop_err", o_se, evq[j].se);
               chk("parallel_data", o_data, evq[j].d);
            end
         end
         if (!hit && (o_dv || o_pe || o_se)) spurious++;
         foreach (bzq[j]) if (bzq[j].cyc == i) chk("busy", o_busy, bzq[j].b);
         if (i == rst_at) begin
            Rst = 1'b0;
            #1;
            chk("rst_busy", o_busy, 1'b0);
            chk("rst_valid", o_dv, 1'b0);
            chk("rst_data", o_data, 9'h0);
         end
         if (rst_at >= 0 && i == rst_at + 3) Rst = 1'b1;
         pin = (i < pinq.size()) ? pinq[i] : 1'b1;
      end
      chk("no_spurious_strobe", spurious, 0);
      pinq.delete();
      evq.delete();
      bzq.delete();
   endtask

   initial begin
      int         p, dw;
      logic [8:0] d;
      bit [1:0]   sv;
      tests = 0; fails = 0;
      pin = 1'b1; sel = 1'b0;
      presc = 6'd8; pen = 1'b0; ptype = 1'b0; two = 1'b0;
      good_w[0] = '0; good_w[1] = '0;
      Rst = 1'b1;
      #2 Rst = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      chk("reset_busy", o_busy, 1'b0);
      chk("reset_valid", o_dv, 1'b0);
      chk("reset_perr", o_pe, 1'b0);
      chk("reset_serr", o_se, 1'b0);
      chk("reset_data", o_data, 9'h0);
      Rst = 1'b1;
      repeat (2) @(posedge Clk);

      // basic 0xA5, P=8, no parity, one stop
      add_frame(8, 8, 9'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 0);
      add_idle(4);
      play(-1);

      // even parity P=16: wrong parity bit, then corrected
      presc = 6'd16; pen = 1'b1; ptype = 1'b0;
      add_frame(8, 16, 9'h53, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 0);
      add_idle(4);
      play(-1);
      add_frame(8, 16, 9'h53, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 0);
      add_idle(4);
      play(-1);

      // start glitch followed by a valid frame
      pen = 1'b0;
      add_glitch(16);
      add_frame(8, 16, 9'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 0);
      add_idle(4);
      play(-1);

      // two stop bits, first one low
      presc = 6'd8; two = 1'b1;
      add_frame(8, 8, 9'h96, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 0);
      add_idle(12);
      play(-1);

      // 7-bit instance, P=63, odd parity, back-to-back frames with spikes
      sel = 1'b1; presc = 6'd63; pen = 1'b1; ptype = 1'b1; two = 1'b0;
      add_frame(7, 63, 9'h7F, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 0);
      add_frame(7, 63, 9'h00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 0);
      add_idle(8);
      play(-1);

      // reset during data bit 3, then a full frame
      sel = 1'b0; presc = 6'd16; pen = 1'b0; ptype = 1'b0; two = 1'b0;
      add_frame(8, 16, 9'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 5 * 16);
      add_idle(20);
      play(2 + 4 * 16 + 8);
      good_w[0] = '0; good_w[1] = '0;
      add_frame(8, 16, 9'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 0);
      add_idle(4);
      play(-1);

      // randomized frames on both instances
      for (int r = 0; r < 16; r++) begin
         sel   = 1'($urandom_range(0, 1));
         dw    = sel ? 7 : 8;
         p     = $urandom_range(4, 24);
         d     = 9'($urandom);
         presc = 6'(p);
         pen   = 1'($urandom_range(0, 1));
         ptype = 1'($urandom_range(0, 1));
         two   = 1'($urandom_range(0, 1));
         sv    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
         add_frame(dw, p, d, pen, ptype, two, 1'($urandom_range(0, 1)) & pen, sv,
                   1'($urandom_range(0, 1)), 0);
         add_idle(p + 4 + $urandom_range(0, 5));
         play(-1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/uart_rx_frame_engine.md
# uart_rx_frame_engine

Parametrised UART receive engine that replaces the fixed 8-bit receiver top. It is a single self-contained block with these features:
- data width set by parameter;
- prescale up to 63 set at runtime;
- optional even/odd parity;
- 1 or 2 stop bits;
- input synchroniser;
- three-sample majority voting;
- per-frame error reporting.

It sits between the serial pin and the register/FIFO layer. It delivers one parallel word per good frame as a single-cycle strobe.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal range 5..9
- PRESC_W, 6, width of Prescale input; legal Prescale values 4..2^PRESC_W-1

- Clk  in  1  system clock; all state on rising edge
- Rst  in  1  asynchronous, active-low reset
- RX_IN  in  1  serial line; idle high; asynchronous to Clk
- Prescale  in  PRESC_W  Clk cycles per bit
- Parity_EN  in  1  1 = parity bit present after data
- Parity_type  in  1  0 = even, 1 = odd
- Two_stop  in  1  1 = two stop bits, 0 = one stop bit
- Parallel_data  out  DATA_WIDTH  last good word, LSB = first received bit
- Data_valid  out  1  one-cycle strobe, good frame
- Parity_err  out  1  one-cycle strobe, parity mismatch
- Stop_err  out  1  one-cycle strobe, any stop bit sampled 0
- Busy  out  1  high whenever state ≠ IDLE

## Operation
- **Synchroniser.** RX_IN passes through two flops to produce rx_s. Both flops reset to 1.
- **Configuration latch.** Prescale, Parity_EN, Parity_type and Two_stop are latched on the IDLE→START transition. Changes mid-frame have no effect.
- **Counters.**
  - edge_cnt counts 0..P-1, where P is the latched Prescale.
  - half = P>>1.
  - bit_cnt counts bits within the DATA and STOP states.
- **Sampling.**
  - rx_s is captured at edge_cnt = half-1, half and half+1.
  - The bit value is the majority of the three samples.
  - The majority is valid from edge_cnt = half+1 onward (combinational on the third sample).
- **States.**
  - IDLE: when rx_s = 0, go to START. The detection cycle D counts as edge 0.
  - START: at edge_cnt = P-1, evaluate the majority. If 1, it is a glitch: go to IDLE with no strobe. If 0, go to DATA with bit_cnt = 0.
  - DATA: shift the majority into the shift register LSB-first at edge half+1. At edge P-1 of bit DATA_WIDTH-1, go to PARITY if Parity_EN, else STOP.
  - PARITY: store the majority at edge half+1. At edge P-1, go to STOP.
  - STOP: sample each stop bit at edge half+1 and OR any 0 into a sticky stop-error flag. The frame ends at edge half+1 of the final stop bit, not at edge P-1. This leaves half a bit of margin for the next start edge.
- **Frame completion** (registered on the cycle after the final stop sample):
  - Stop_err = sticky stop-error OR (final stop sample == 0).
  - Parity_err = Parity_EN AND (XOR(data, parity bit) ≠ Parity_type).
  - If neither error: Parallel_data ← shift register and Data_valid = 1.
  - If either error: Parallel_data holds its old value, Data_valid = 0, and the applicable error strobe(s) = 1.
  - The state returns to IDLE in the same cycle.
- **Reset values.** Parallel_data = 0; Data_valid, Parity_err, Stop_err and Busy = 0; state = IDLE; counters = 0.
- **Reset mid-frame.** The partial frame is discarded with no strobe. After reset release the block waits for a fresh falling edge.
- **Line held low in IDLE** (break): a frame is received; Stop_err is raised. The block then re-enters START immediately while rx_s stays 0. This is repeated per frame time and is legal.

## Timing
- N = 1 + DATA_WIDTH + Parity_EN + (Two_stop ? 2 : 1) − 1, the index of the final stop bit.
- The final sample occurs at cycle D + N·P + half + 1.
- The strobes are high in exactly cycle D + N·P + half + 2.
- Busy is high from D+1 through D + N·P + half + 1 inclusive, and low in the strobe cycle.
- The earliest next detection is the strobe cycle itself, if rx_s = 0 then.
- Pin-to-D latency is 2 cycles (synchroniser).
- A glitch returns to IDLE at D+P. Busy is low from D+P.
- The strobes are mutually exclusive with Data_valid. Parity_err and Stop_err may be high together.

## Test plan
- **Basic frame.** DATA_WIDTH=8, P=8, no parity, 1 stop; send 0xA5 → Data_valid high only in cycle D+78, Parallel_data=0xA5, Busy low at D+78.
- **Parity error.** P=16, even parity; send 0x53 with parity bit 1 (correct is 0) → Parity_err=1 at D+16·10+10 = D+170, Data_valid=0, Parallel_data unchanged from the previous 0xA5. Resend with parity 0 → Data_valid, 0x53.
- **Start glitch.** P=16; hold RX_IN low for 3 cycles, then high → no strobe, Busy falls at D+16. A following valid frame 0x3C is received correctly.
- **Two stop bits.** Two_stop=1, P=8; first stop bit driven 0, second 1 → Stop_err=1, Data_valid=0, strobe at D+8·10+6 = D+86.
- **Parameter and noise.** DATA_WIDTH=7, P=63, odd parity; back-to-back frames 0x7F then 0x00 with no idle gap, plus a single-cycle inverted spike at edge half in every bit → both words valid with correct values (majority vote rejects the spike).
- **Reset mid-frame.** Assert Rst low during DATA bit 3 → all outputs 0 immediately, no strobe. After release, the next full frame is received.
